// File: rtl/spi_session_if.sv
// spi_session_if: bundle between the SPI sequence detector / pin mux side
// (master) and spi_session_decoder (slave).
//   start, cpol, cpha : session start pulse and SPI mode, sampled on start
//   sclk, sin         : SPI clock and MOSI, already synchronised to clk
//   scs, sindex       : one-hot chip select and decoded index (all-ones = none)
//   active, done, err : session status
interface spi_session_if #(
  parameter int SELECT_SIZE = 8,
  parameter int CS_COUNT    = 4
);
  logic                   start;
  logic                   cpol;
  logic                   cpha;
  logic                   sclk;
  logic                   sin;
  logic [CS_COUNT-1:0]    scs;
  logic [SELECT_SIZE-1:0] sindex;
  logic                   active;
  logic                   done;
  logic                   err;

  modport master (output start, cpol, cpha, sclk, sin,
                  input  scs, sindex, active, done, err);
  modport slave  (input  start, cpol, cpha, sclk, sin,
                  output scs, sindex, active, done, err);
endinterface

// File: rtl/spi_session_decoder.sv
// spi_session_decoder: after a start pulse, shifts an in-band header
// {select, byte count} off sin, then drives one-hot scs[select] for
// count*8 sclk periods. All four SPI modes.
//   clk, rst : system clock (oversamples sclk >= 4x), sync active-high reset
//   bus      : spi_session_if.slave (start/cpol/cpha/sclk/sin in,
//              scs/sindex/active/done/err out, all registered)
module spi_session_decoder #(
  parameter int SELECT_SIZE = 8,
  parameter int CYCLES_SIZE = 16,
  parameter int CS_COUNT    = 4
) (
  input  logic          clk,
  input  logic          rst,
  spi_session_if.slave  bus
);
  localparam int HDR_W  = SELECT_SIZE + CYCLES_SIZE;
  localparam int BCNT_W = $clog2(HDR_W + 1);
  localparam int REM_W  = CYCLES_SIZE + 3;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_ACTIVE} state_t;
  state_t state_q, state_d;

  logic                   cpol_q, cpol_d, cpha_q, cpha_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [HDR_W-1:0]       hdr_q, hdr_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [CS_COUNT-1:0]    scs_q, scs_d;
  logic [SELECT_SIZE-1:0] sindex_q, sindex_d;
  logic                   active_q, active_d, done_q, done_d, err_q, err_d;

  // sclk edge classification relative to the latched idle level
  logic edge_w, lead_w, trail_w, sample_w;
  assign edge_w   = bus.sclk != sclk_prev_q;
  assign lead_w   = edge_w && (bus.sclk != cpol_q);
  assign trail_w  = edge_w && (bus.sclk == cpol_q);
  assign sample_w = cpha_q ? trail_w : lead_w;

  // Header decode. In CPHA=1 the final sample and the header-ending trailing
  // edge coincide, so decode from the header including this cycle's bit.
  logic                   shift_en, hdr_end, last_w, idx_bad;
  logic [HDR_W-1:0]       hdr_shift, hdr_now;
  logic [SELECT_SIZE-1:0] idx_w;
  logic [CYCLES_SIZE-1:0] n_w;

  assign shift_en  = (state_q == S_HEADER) && sample_w && (bcnt_q != BCNT_W'(HDR_W));
  assign hdr_shift = {hdr_q[HDR_W-2:0], bus.sin};
  assign hdr_now   = shift_en ? hdr_shift : hdr_q;
  assign hdr_end   = (state_q == S_HEADER) && trail_w &&
                     ((bcnt_q == BCNT_W'(HDR_W)) ||
                      (shift_en && bcnt_q == BCNT_W'(HDR_W - 1)));
  assign idx_w     = hdr_now[HDR_W-1 -: SELECT_SIZE];
  assign n_w       = hdr_now[CYCLES_SIZE-1:0];
  assign idx_bad   = idx_w >= SELECT_SIZE'(CS_COUNT);
  assign last_w    = (state_q == S_ACTIVE) && trail_w && (rem_q == REM_W'(1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    if (bus.start) state_d = S_HEADER;
    else begin
      case (state_q)
        S_HEADER: if (hdr_end) state_d = (idx_bad || n_w == '0) ? S_IDLE : S_ACTIVE;
        S_ACTIVE: if (last_w)  state_d = S_IDLE;
        default:  ;
      endcase
    end
  end

  // datapath / output next values
  always_comb begin
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    sclk_prev_d = bus.sclk;
    hdr_d       = hdr_q;
    bcnt_d      = bcnt_q;
    rem_d       = rem_q;
    scs_d       = scs_q;
    sindex_d    = sindex_q;
    active_d    = active_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    if (bus.start) begin
      // start wins over any edge this cycle; also aborts a running session
      cpol_d      = bus.cpol;
      cpha_d      = bus.cpha;
      sclk_prev_d = bus.cpol;
      hdr_d       = '0;
      bcnt_d      = '0;
      scs_d       = '0;
      active_d    = 1'b0;
      sindex_d    = '1;
    end else begin
      if (shift_en) begin
        hdr_d  = hdr_shift;
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
      if (hdr_end) begin
        done_d = idx_bad || (n_w == '0);
        err_d  = idx_bad;
        if (!idx_bad) sindex_d = idx_w;
        if (!idx_bad && n_w != '0) begin
          scs_d    = CS_COUNT'(1) << idx_w;
          active_d = 1'b1;
          rem_d    = {n_w, 3'b000};
        end
      end
      if ((state_q == S_ACTIVE) && trail_w) begin
        rem_d = rem_q - REM_W'(1);
        if (last_w) begin
          scs_d    = '0;
          active_d = 1'b0;
          done_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      sclk_prev_q <= 1'b0;
      hdr_q       <= '0;
      bcnt_q      <= '0;
      rem_q       <= '0;
      scs_q       <= '0;
      sindex_q    <= '1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      sclk_prev_q <= sclk_prev_d;
      hdr_q       <= hdr_d;
      bcnt_q      <= bcnt_d;
      rem_q       <= rem_d;
      scs_q       <= scs_d;
      sindex_q    <= sindex_d;
      active_q    <= active_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.scs    = scs_q;
  assign bus.sindex = sindex_q;
  assign bus.active = active_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_spi_session_decoder.sv
// tb_spi_session_decoder: drives SPI sessions period by period and keeps the
// expected outputs as session-level facts (header fields, byte count, which
// trailing edge ends what). A negedge process compares every cycle; a few
// literal checks pin cycle counts and indices for the directed cases.
module tb_spi_session_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_session_if #(.SELECT_SIZE(8), .CS_COUNT(4)) bus();

  spi_session_decoder #(.SELECT_SIZE(8), .CYCLES_SIZE(16), .CS_COUNT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [3:0] exp_scs  = 4'b0;
  logic [7:0] exp_idx  = 8'hFF;
  logic       exp_act  = 1'b0;
  logic       exp_done = 1'b0;
  logic       exp_err  = 1'b0;

  int scs_hi = 0, done_cnt = 0, err_cnt = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("scs",    32'(bus.scs),    32'(exp_scs));
      cmp("sindex", 32'(bus.sindex), 32'(exp_idx));
      cmp("active", 32'(bus.active), 32'(exp_act));
      cmp("done",   32'(bus.done),   32'(exp_done));
      cmp("err",    32'(bus.err),    32'(exp_err));
      if (bus.scs != 4'b0) scs_hi++;
      if (bus.done) done_cnt++;
      if (bus.err)  err_cnt++;
    end
  end

  // one clk; single-cycle pulses expire unless the caller re-asserts them
  task automatic tick();
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endtask

  // one sclk period: idle half, leading edge, active half, trailing edge,
  // returning right after the clk that detects the trailing edge
  task automatic period(input bit cp, input bit ch, input int h, input bit b);
    if (!ch) bus.sin = b;
    repeat (h) tick();
    bus.sclk = ~cp;
    if (ch) bus.sin = b;
    repeat (h) tick();
    bus.sclk = cp;
    tick();
  endtask

  // abort_at >= 0: return with the session still running after that many
  // data periods
  task automatic session(input int sel, input int cnt, input bit cp, input bit ch,
                         input int h, input int abort_at);
    logic [23:0] hdr;
    hdr = {sel[7:0], cnt[15:0]};
    bus.sclk = cp;
    tick();
    bus.start = 1'b1;
    bus.cpol  = cp;
    bus.cpha  = ch;
    tick();
    bus.start = 1'b0;
    exp_scs = 4'b0;
    exp_act = 1'b0;
    exp_idx = 8'hFF;
    for (int p = 0; p < 24; p++) period(cp, ch, h, hdr[23-p]);
    if (sel >= 4) begin
      exp_done = 1'b1;
      exp_err  = 1'b1;
    end else if (cnt == 0) begin
      exp_idx  = sel[7:0];
      exp_done = 1'b1;
    end else begin
      exp_idx = sel[7:0];
      exp_scs = 4'b0001 << sel[1:0];
      exp_act = 1'b1;
      for (int d = 1; d <= 8 * cnt; d++) begin
        if (d - 1 == abort_at) return;
        period(cp, ch, h, 1'($urandom_range(0, 1)));
        if (d == 8 * cnt) begin
          exp_scs  = 4'b0;
          exp_act  = 1'b0;
          exp_done = 1'b1;
        end
      end
    end
  endtask

  task automatic clr_counts();
    scs_hi = 0;
    done_cnt = 0;
    err_cnt = 0;
  endtask

  initial begin
    int sel, cnt, h, r;
    bit cp, ch;
    bus.start = 1'b0;
    bus.cpol  = 1'b0;
    bus.cpha  = 1'b0;
    bus.sclk  = 1'b0;
    bus.sin   = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    cmp("reset_sindex", 32'(bus.sindex), 32'h0000_00FF);
    cmp("reset_scs",    32'(bus.scs),    32'h0);

    // mode 0, sel 2, one byte: 8 periods of 5 clk
    clr_counts();
    session(2, 1, 1'b0, 1'b0, 2, -1);
    tick();
    cmp("m0_scs_cycles", 32'(scs_hi),     32'd40);
    cmp("m0_done_cnt",   32'(done_cnt),   32'd1);
    cmp("m0_err_cnt",    32'(err_cnt),    32'd0);
    cmp("m0_sindex",     32'(bus.sindex), 32'h02);

    // mode 3, sel 0, three bytes: 24 periods
    clr_counts();
    session(0, 3, 1'b1, 1'b1, 2, -1);
    tick();
    cmp("m3_scs_cycles", 32'(scs_hi),   32'd120);
    cmp("m3_done_cnt",   32'(done_cnt), 32'd1);

    // invalid indices
    clr_counts();
    session(255, 16, 1'b0, 1'b0, 2, -1);
    session(5, 16, 1'b1, 1'b0, 2, -1);
    tick();
    cmp("bad_scs_cycles", 32'(scs_hi),     32'd0);
    cmp("bad_err_cnt",    32'(err_cnt),    32'd2);
    cmp("bad_sindex",     32'(bus.sindex), 32'hFF);

    // zero-length session
    clr_counts();
    session(1, 0, 1'b0, 1'b1, 3, -1);
    tick();
    cmp("zero_done_cnt", 32'(done_cnt),   32'd1);
    cmp("zero_sindex",   32'(bus.sindex), 32'h01);

    // mode 1 aborted by a new start after 5 data periods
    clr_counts();
    session(3, 2, 1'b0, 1'b1, 2, 5);
    session(2, 1, 1'b0, 1'b1, 2, -1);
    tick();
    cmp("abort_done_cnt", 32'(done_cnt), 32'd1);

    // reset mid-ACTIVE, then sclk activity with no start
    session(0, 2, 1'b0, 1'b0, 2, 3);
    rst = 1'b1;
    tick();
    exp_scs = 4'b0;
    exp_act = 1'b0;
    exp_idx = 8'hFF;
    rst = 1'b0;
    clr_counts();
    for (int p = 0; p < 4; p++) period(1'b0, 1'b0, 2, 1'b1);
    cmp("rst_scs_cycles", 32'(scs_hi),   32'd0);
    cmp("rst_done_cnt",   32'(done_cnt), 32'd0);

    // randomized sessions
    for (int i = 0; i < 30; i++) begin
      cp  = 1'($urandom_range(0, 1));
      ch  = 1'($urandom_range(0, 1));
      h   = int'($urandom_range(2, 4));
      r   = int'($urandom_range(0, 9));
      sel = (r < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 255));
      cnt = int'($urandom_range(0, 3));
      session(sel, cnt, cp, ch, h, (r == 9 && cnt > 1) ? int'($urandom_range(0, 7)) : -1);
      repeat (int'($urandom_range(1, 6))) begin
        bus.sin = 1'($urandom_range(0, 1));
        tick();
      end
    end
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
